xor_stream_descrambler: RTL and testbench

- Receive end of the team's nibble XOR cipher path. The encoder side XORs plaintext with a key. This block takes ciphertext nibbles, regenerates the same keystream from a shared seed, and XORs them back to recover plaintext.
- Also outputs the bitwise complement of the recovered nibble, matching the true/complement pair convention of the XOR table block.
- Sits between the link input stream and the downstream consumer.
- Uses valid/ready on both sides and processes fixed-length frames.

---
 rtl/xor_cipher_pkg.sv | 29 ++
 rtl/xor_stream_descrambler_lfsr_keystream.sv | 33 +++
 rtl/xor_stream_descrambler.sv | 112 +++++++++++
 tb/tb_xor_stream_descrambler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the nibble XOR cipher path: FSM states, default widths
// and the 4-step Galois LFSR advance used by both encoder and descrambler.
package xor_cipher_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_LFSR_W = 8;
    localparam logic [DEF_LFSR_W-1:0] DEF_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One keystream nibble consumes four Galois shifts of the register.
    function automatic logic [DEF_LFSR_W-1:0] lfsr_step4(
        input logic [DEF_LFSR_W-1:0] lfsr,
        input logic [DEF_LFSR_W-1:0] taps
    );
        logic [DEF_LFSR_W-1:0] s;
        s = lfsr;
        for (int i = 0; i < 4; i++) begin
            if (s[0]) s = (s >> 1) ^ taps;
            else      s = s >> 1;
        end
        return s;
    endfunction

endpackage

// File: rtl/xor_stream_descrambler_lfsr_keystream.sv
// Keystream generator: seed load with zero-seed substitution, advance by one
// nibble (4 Galois steps) per enable, key taken from the low bits.
module lfsr_keystream
    import xor_cipher_pkg::*;
#(
    parameter int unsigned          LFSR_W = DEF_LFSR_W,
    parameter int unsigned          DATA_W = DEF_DATA_W,
    parameter logic [LFSR_W-1:0]    TAPS   = DEF_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_adv,
    output logic [DATA_W-1:0] o_key
);

    logic [LFSR_W-1:0] r_lfsr;

    // An all-zero state never leaves zero, so it is swapped for 1 on load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= '0;
        end else if (i_load) begin
            r_lfsr <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
        end else if (i_adv) begin
            r_lfsr <= lfsr_step4(r_lfsr, TAPS);
        end
    end

    assign o_key = r_lfsr[DATA_W-1:0];

endmodule

// File: rtl/xor_stream_descrambler.sv
// Receive-side nibble descrambler: XORs ciphertext with the regenerated keystream,
// single-entry output buffer with valid/ready on both sides, fixed-length frames.
module xor_stream_descrambler
    import xor_cipher_pkg::*;
#(
    parameter int unsigned          DATA_W    = DEF_DATA_W,
    parameter int unsigned          LFSR_W    = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0]    TAPS      = DEF_TAPS,
    parameter int unsigned          FRAME_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_data_n,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned     CNT_W       = 8;
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_out_data_n;
    logic              r_frame_done;

    logic              w_in_acc;
    logic              w_load;
    logic [DATA_W-1:0] w_key;
    logic [DATA_W-1:0] w_plain;
    logic [CNT_W-1:0]  w_count_nxt;

    lfsr_keystream #(
        .LFSR_W (LFSR_W),
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_ks (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_seed (seed),
        .i_adv  (w_in_acc),
        .o_key  (w_key)
    );

    // Ready also when the held word leaves this cycle, giving one nibble per clock.
    assign in_ready    = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_in_acc    = in_valid && in_ready;
    assign w_load      = (r_state == IDLE) && seed_valid;
    assign w_plain     = in_data ^ w_key;
    assign w_count_nxt = r_count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_data_n <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (seed_valid) begin
                        r_state <= RUN;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    if (w_in_acc) begin
                        r_count <= w_count_nxt;
                        if (w_count_nxt == FRAME_LEN_C) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_out_valid || out_ready) begin
                        r_state      <= IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A simultaneous pop and accept simply reloads the register.
            if (w_in_acc) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_plain;
                r_out_data_n <= ~w_plain;
            end else if (r_out_valid && out_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_data_n = r_out_data_n;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed bench for xor_stream_descrambler: one short-frame and one full-frame instance.
module tb_xor_stream_descrambler;
    import xor_cipher_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: FRAME_LEN = 2
    logic       a_rst_n, a_seed_valid, a_in_valid, a_out_ready;
    logic [7:0] a_seed;
    logic [3:0] a_in_data;
    logic       a_in_ready, a_out_valid, a_busy, a_frame_done;
    logic [3:0] a_out_data, a_out_data_n;

    // Instance B: FRAME_LEN = 16
    logic       b_rst_n, b_seed_valid, b_in_valid, b_out_ready;
    logic [7:0] b_seed;
    logic [3:0] b_in_data;
    logic       b_in_ready, b_out_valid, b_busy, b_frame_done;
    logic [3:0] b_out_data, b_out_data_n;

    xor_stream_descrambler #(.FRAME_LEN(2)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .seed_valid(a_seed_valid), .seed(a_seed),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_data_n(a_out_data_n), .busy(a_busy), .frame_done(a_frame_done)
    );

    xor_stream_descrambler #(.FRAME_LEN(16)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .seed_valid(b_seed_valid), .seed(b_seed),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_data_n(b_out_data_n), .busy(b_busy), .frame_done(b_frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_seed_valid = 1'b0; b_seed_valid = 1'b0;
        a_seed = 8'h00; b_seed = 8'h00;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_in_data = 4'h0; b_in_data = 4'h0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        step(); step();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        n_vec++;
        if ({a_out_valid, a_in_ready, a_busy, a_frame_done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl_a: got %b want 0000", {a_out_valid, a_in_ready, a_busy, a_frame_done});
        end
        n_vec++;
        if ({a_out_data, a_out_data_n} !== 8'h0F) begin
            n_err++; $display("FAIL reset_data_a: got %h want 0f", {a_out_data, a_out_data_n});
        end
        n_vec++;
        if ({b_out_valid, b_in_ready, b_busy, b_frame_done, b_out_data_n} !== 8'h0F) begin
            n_err++; $display("FAIL reset_b: got %h want 0f", {b_out_valid, b_in_ready, b_busy, b_frame_done, b_out_data_n});
        end
    endtask

    task automatic test_basic_decode();
        a_seed = 8'h01; a_seed_valid = 1'b1;
        step();
        a_seed_valid = 1'b0;
        n_vec++;
        if ({a_in_ready, a_busy} !== 2'b11) begin
            n_err++; $display("FAIL basic_run: in_ready,busy got %b want 11", {a_in_ready, a_busy});
        end
        a_in_valid = 1'b1; a_in_data = 4'h5;
        step();
        n_vec++;
        if ({a_out_valid, a_out_data, a_out_data_n} !== 9'h14B) begin
            n_err++; $display("FAIL basic_n0: got %h want 14b", {a_out_valid, a_out_data, a_out_data_n});
        end
        n_vec++;
        if (dut_a.u_ks.r_lfsr !== 8'h17) begin
            n_err++; $display("FAIL basic_lfsr: got %h want 17", dut_a.u_ks.r_lfsr);
        end
        a_in_data = 4'h6;
        step();
        a_in_valid = 1'b0;
        #1;
        n_vec++;
        if ({a_out_valid, a_out_data, a_out_data_n} !== 9'h11E) begin
            n_err++; $display("FAIL basic_n1: got %h want 11e", {a_out_valid, a_out_data, a_out_data_n});
        end
        n_vec++;
        if ({a_in_ready, a_busy, a_frame_done} !== 3'b010) begin
            n_err++; $display("FAIL basic_drain: in_ready,busy,done got %b want 010", {a_in_ready, a_busy, a_frame_done});
        end
        step();
        n_vec++;
        if ({a_frame_done, a_busy, a_out_valid} !== 3'b100) begin
            n_err++; $display("FAIL basic_done: done,busy,out_valid got %b want 100", {a_frame_done, a_busy, a_out_valid});
        end
        step();
        n_vec++;
        if ({a_frame_done, a_busy} !== 2'b00) begin
            n_err++; $display("FAIL basic_done_pulse: done,busy got %b want 00", {a_frame_done, a_busy});
        end
    endtask

    task automatic test_zero_seed();
        a_seed = 8'h00; a_seed_valid = 1'b1;
        step();
        a_seed_valid = 1'b0;
        a_in_valid = 1'b1; a_in_data = 4'h5;
        step();
        n_vec++;
        if ({a_out_data, a_out_data_n} !== 8'h4B) begin
            n_err++; $display("FAIL zero_seed_n0: got %h want 4b", {a_out_data, a_out_data_n});
        end
        a_in_data = 4'h6;
        step();
        a_in_valid = 1'b0;
        n_vec++;
        if (a_out_data !== 4'h1) begin
            n_err++; $display("FAIL zero_seed_n1: got %h want 1", a_out_data);
        end
        step(); step();
    endtask

    task automatic test_back_pressure();
        a_seed = 8'h01; a_seed_valid = 1'b1; a_out_ready = 1'b1;
        step();
        a_seed_valid = 1'b0;
        a_in_valid = 1'b1; a_in_data = 4'h5;
        step();
        a_out_ready = 1'b0; a_in_data = 4'h6;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({a_out_valid, a_in_ready, a_out_data} !== 6'b10_0100) begin
                n_err++; $display("FAIL stall_%0d: valid,ready,data got %b want 100100", i, {a_out_valid, a_in_ready, a_out_data});
            end
            step();
        end
        a_out_ready = 1'b1;
        #1;
        n_vec++;
        if (a_in_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release_ready: got %b want 1", a_in_ready);
        end
        step();
        a_in_valid = 1'b0;
        n_vec++;
        if ({a_out_valid, a_out_data, a_out_data_n} !== 9'h11E) begin
            n_err++; $display("FAIL stall_second: got %h want 11e", {a_out_valid, a_out_data, a_out_data_n});
        end
        step();
        n_vec++;
        if ({a_frame_done, a_out_valid} !== 2'b10) begin
            n_err++; $display("FAIL stall_done: done,valid got %b want 10", {a_frame_done, a_out_valid});
        end
        step();
    endtask

    task automatic test_round_trip();
        logic [7:0] lfsr;
        logic [3:0] pt [16];
        logic [3:0] ct [16];
        lfsr = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            pt[i] = 4'($urandom_range(0, 15));
            ct[i] = pt[i] ^ lfsr[3:0];
            lfsr  = lfsr_step4(lfsr, DEF_TAPS);
        end
        b_seed = 8'hA5; b_seed_valid = 1'b1; b_out_ready = 1'b1;
        step();
        b_seed_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_in_valid = 1'b1; b_in_data = ct[i];
            b_seed_valid = (i == 5); b_seed = 8'h00;
            step();
            n_vec++;
            if ({b_out_valid, b_out_data, b_out_data_n} !== {1'b1, pt[i], ~pt[i]}) begin
                n_err++; $display("FAIL round_trip_%0d: got %h want %h", i, {b_out_valid, b_out_data, b_out_data_n}, {1'b1, pt[i], ~pt[i]});
            end
        end
        b_in_valid = 1'b0; b_seed_valid = 1'b0;
        #1;
        n_vec++;
        if ({b_in_ready, b_busy} !== 2'b01) begin
            n_err++; $display("FAIL round_trip_drain: ready,busy got %b want 01", {b_in_ready, b_busy});
        end
        step();
        n_vec++;
        if ({b_frame_done, b_busy} !== 2'b10) begin
            n_err++; $display("FAIL round_trip_done: done,busy got %b want 10", {b_frame_done, b_busy});
        end
        step();
    endtask

    task automatic test_midframe_reset();
        b_seed = 8'h01; b_seed_valid = 1'b1;
        step();
        b_seed_valid = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in_data = 4'(5 + i);
            step();
        end
        b_in_valid = 1'b0; b_rst_n = 1'b0;
        step();
        b_rst_n = 1'b1;
        #1;
        n_vec++;
        if ({b_out_valid, b_in_ready, b_busy, b_frame_done, b_out_data, b_out_data_n} !== 12'h00F) begin
            n_err++; $display("FAIL midreset_outputs: got %h want 00f", {b_out_valid, b_in_ready, b_busy, b_frame_done, b_out_data, b_out_data_n});
        end
        n_vec++;
        if (dut_b.u_ks.r_lfsr !== 8'h00) begin
            n_err++; $display("FAIL midreset_lfsr: got %h want 00", dut_b.u_ks.r_lfsr);
        end
        b_seed = 8'h01; b_seed_valid = 1'b1;
        step();
        b_seed_valid = 1'b0;
        b_in_valid = 1'b1; b_in_data = 4'h5;
        step();
        b_in_valid = 1'b0;
        n_vec++;
        if ({b_out_valid, b_out_data, b_out_data_n} !== 9'h14B) begin
            n_err++; $display("FAIL midreset_restart: got %h want 14b", {b_out_valid, b_out_data, b_out_data_n});
        end
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_zero_seed();
        test_back_pressure();
        test_round_trip();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
